// File: rtl/r8_booth_seq_mult_if.sv
// r8_booth_seq_mult_if: operand and product valid/ready channels of the sequential Booth multiplier
interface r8_booth_seq_mult_if #(parameter int N = 8);
   logic           in_valid;
   logic           in_ready;
   logic [N-1:0]   a;
   logic [N-1:0]   b;
   logic           out_valid;
   logic           out_ready;
   logic [2*N-1:0] p;
   modport master (output in_valid, a, b, out_ready, input in_ready, out_valid, p);
   modport slave  (input in_valid, a, b, out_ready, output in_ready, out_valid, p);
endinterface

// File: rtl/r8_booth_seq_mult.sv
// r8_booth_seq_mult: sequential radix-8 Booth multiplier, one digit per clock, shared selector and accumulator
module r8_booth_seq_mult #(
   parameter int N      = 8,
   parameter bit SIGNED = 1
) (
   input  logic                clk,
   input  logic                rst,
   r8_booth_seq_mult_if.slave  s_if,
   output logic                busy_o,
   output logic [4:0]          digit_code_o
);
   localparam int E  = SIGNED ? N : N + 1;
   localparam int D  = (E + 2) / 3;
   localparam int BW = 3 * D;
   localparam int AW = 2 * N + 3;
   localparam int CW = $clog2(D + 1);
   typedef enum logic [1:0] {IDLE, PRE, RUN, DONE} state_e;
   state_e          state_q;
   logic [E-1:0]    x_q;
   logic [E+1:0]    x3_q;
   logic [BW:0]     y_q;
   logic [AW-1:0]   acc_q, acc_d;
   logic [CW-1:0]   cnt_q;
   logic [E-1:0]    a_ext;
   logic [BW-1:0]   b_ext;
   logic [3:0]      y;
   logic [4:0]      code;
   logic signed [AW-1:0] x1_w, x3_w, mag_w, pp_w;
   logic            accept;
   assign a_ext  = SIGNED ? E'($signed(s_if.a)) : E'(s_if.a);
   assign b_ext  = SIGNED ? BW'($signed(s_if.b)) : BW'(s_if.b);
   assign accept = s_if.in_valid & s_if.in_ready;
   // y_q is shifted three places per digit, so the current window always sits in the low four bits
   assign y     = y_q[3:0];
   assign code  = {y[3],
                   ~(y[0] ^ y[1]) & ~(y[1] ^ y[2]) & (y[2] ^ y[3]),
                   (y[0] ^ y[1]) & (y[2] ^ y[3]),
                   ~(y[0] ^ y[1]) & (y[1] ^ y[2]),
                   (y[0] ^ y[1]) & ~(y[2] ^ y[3])};
   assign x1_w  = AW'($signed(x_q));
   assign x3_w  = AW'($signed(x3_q));
   assign mag_w = code[0] ? x1_w : code[1] ? x1_w <<< 1 : code[2] ? x3_w : code[3] ? x1_w <<< 2 : '0;
   assign pp_w  = code[4] ? -mag_w : mag_w;
   assign acc_d = acc_q + ($unsigned(pp_w) << (3 * cnt_q));
   assign s_if.in_ready  = (state_q == IDLE) | ((state_q == DONE) & s_if.out_ready);
   assign s_if.out_valid = state_q == DONE;
   assign s_if.p         = acc_q[2*N-1:0];
   assign busy_o         = (state_q == PRE) | (state_q == RUN);
   assign digit_code_o   = (state_q == RUN) ? code : 5'd0;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         x_q     <= '0;
         x3_q    <= '0;
         y_q     <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
      end else begin
         if (accept) begin
            x_q     <= a_ext;
            y_q     <= {b_ext, 1'b0};
            state_q <= PRE;
         end else if (state_q == DONE && s_if.out_ready) begin
            state_q <= IDLE;
         end
         if (state_q == PRE) begin
            x3_q    <= {x_q[E-1], x_q[E-1], x_q} + {x_q[E-1], x_q, 1'b0};
            cnt_q   <= '0;
            acc_q   <= '0;
            state_q <= RUN;
         end
         if (state_q == RUN) begin
            acc_q   <= acc_d;
            y_q     <= y_q >> 3;
            cnt_q   <= cnt_q + 1'b1;
            state_q <= (cnt_q == CW'(D - 1)) ? DONE : RUN;
         end
      end
   end
endmodule
